pe_out_collector: RTL and testbench
===================================

Name: pe_out_collector

Overview:
- Downstream drain stage of the systolic PE array.
- Consumes the staggered per-row out_fifo read strobes (out_rd_en[X:1]) and the X parallel out_fifo data lanes, and tags each result with its row/column.
- Funnels results through a BUF_DEPTH-entry buffer onto one valid/ready result stream for the EKF datapath, in row-major order, with sticky error flags.

Parameters:
- X, 3, PE rows = number of out_fifo lanes.
- Y, 3, PE columns = results per row per frame.
- OUT_LEN, 8, result word width.
- RD_LAT, 1, out_fifo read latency in cycles (1..4).
- BUF_DEPTH, 8, result buffer entries (power of 2, >=2).

Ports:
- clk  in  1  clock.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous flush of buffer, counters and flags.
- out_rd_en  in  X  per-lane out_fifo read strobe, bit i = row i (1-based).
- out_data  in  X*OUT_LEN  lane i at [i*OUT_LEN-1 : (i-1)*OUT_LEN].
- res_data  out  OUT_LEN  result word.
- res_row  out  clog2(X)  row index, 0-based.
- res_col  out  clog2(Y)  column index, 0-based.
- res_last  out  1  entry is row X-1, col Y-1.
- res_val  out  1  result valid.
- res_rdy  in  1  consumer ready.
- busy  out  1  capture pending or buffer non-empty.
- overflow  out  1  sticky: result dropped on full buffer.
- collide  out  1  sticky: more than one lane strobed in one cycle.

Behaviour:
- Reset (async): buffer empty, all counters 0, delay lines 0. Outputs res_val, res_last, busy, overflow, collide = 0; res_data, res_row, res_col = 0.
- Capture alignment:
  - out_rd_en is delayed RD_LAT cycles by an X-wide shift register, giving cap_en.
  - When cap_en[i]=1, out_data lane i is sampled in that cycle.
- Lane select:
  - If several cap_en bits are set, only the lowest index is captured; collide is set the next cycle.
  - The other lanes' column counters still advance.
- Column counters:
  - One per lane, 0..Y-1; increments on each cap_en[i] and wraps Y-1 -> 0.
  - Tag pushed = {row=i-1, col=counter before increment, last=(i==X && col==Y-1)}.
- Buffer: circular FIFO, BUF_DEPTH entries of {data,row,col,last}; write and read pointers one bit wider than address.
  - Push when capture occurs and (not full, or pop in the same cycle).
  - Push when full with no pop: entry dropped, overflow set next cycle; existing contents are untouched.
  - Pop when res_val && res_rdy.
  - Push on empty: res_val rises the cycle after the push edge. There is no bypass, so the minimum strobe-to-res_val latency is RD_LAT+1 cycles.
  - Outputs res_data/row/col/last are registered from the head entry and hold stable while res_val && !res_rdy.
- busy = |cap_en delay line || !empty.
- clear:
  - Empties the buffer, zeroes counters, the delay line, overflow and collide; res_val=0 next cycle.
  - Has priority over a same-cycle push/pop.
- Reset mid-frame: everything returns to reset state; the next strobe is col 0.
- Sticky flags clear only on reset or clear.
- Widths: counters use clog2(Y), row uses clog2(X), minimum 1 bit each.

Test Plan:
- Reset: assert sys_rst_n=0 mid-traffic -> all outputs 0 immediately; after release, first capture tagged row 0 col 0.
- Full frame, res_rdy=1, X=Y=3, RD_LAT=1:
  - Stimulus: lane i strobed 3 cycles, lanes staggered by 3 cycles from cycle 10; data 0x11..0x33.
  - Required: res_val first at cycle 12; 9 words 0x11,0x12,0x13,0x21,...,0x33 in order with matching row/col; res_last only with 0x33; busy low afterward.
- Backpressure: res_rdy=0 for the whole frame -> 8 entries held, 9th (0x33) dropped, overflow=1. Then res_rdy=1 -> 0x11..0x32 drained in order, res_last never asserted.
- Full with simultaneous pop: fill 8 entries, then capture while res_rdy=1 -> pushed entry accepted, overflow stays 0, count stays 8.
- Collision: out_rd_en=3'b011 in one cycle with lane1=0xA1, lane2=0xB2 -> only 0xA1 pushed (row 0), collide=1, lane2 column counter advanced to 1.
- clear mid-frame: after 4 results with res_rdy=0, pulse clear -> res_val=0 next cycle, flags 0; next strobe on lane 1 tagged col 0.

Source files
------------

// File: rtl/pe_out_collector_if.sv
// Result-drain bundle between PE out_fifo lanes, the collector and the EKF consumer.
// Latency: none, this file only carries wires.
// Backpressure: res_rdy is driven by the consumer and res_val by the collector.
interface pe_out_collector_if #(
   parameter int X       = 3,
   parameter int Y       = 3,
   parameter int OUT_LEN = 8
);
   localparam int RW = (X > 1) ? $clog2(X) : 1;
   localparam int CW = (Y > 1) ? $clog2(Y) : 1;

   logic                   clear;
   logic [X-1:0]           out_rd_en;
   logic [X*OUT_LEN-1:0]   out_data;
   logic [OUT_LEN-1:0]     res_data;
   logic [RW-1:0]          res_row;
   logic [CW-1:0]          res_col;
   logic                   res_last;
   logic                   res_val;
   logic                   res_rdy;
   logic                   busy;
   logic                   overflow;
   logic                   collide;

   modport master (
      output clear, out_rd_en, out_data, res_rdy,
      input  res_data, res_row, res_col, res_last, res_val, busy, overflow, collide
   );

   modport slave (
      input  clear, out_rd_en, out_data, res_rdy,
      output res_data, res_row, res_col, res_last, res_val, busy, overflow, collide
   );
endinterface

// File: rtl/pe_out_collector.sv
// Tags PE out_fifo results with row/col and funnels them through a circular buffer to one stream.
// Latency: strobe to res_val is RD_LAT+1 cycles on an empty buffer (no bypass path).
// Backpressure: res_rdy stalls the head; a capture into a full buffer without a pop is dropped and flagged.
module pe_out_collector #(
   parameter int X         = 3,
   parameter int Y         = 3,
   parameter int OUT_LEN   = 8,
   parameter int RD_LAT    = 1,
   parameter int BUF_DEPTH = 8
) (
   input logic              clk,
   input logic              sys_rst_n,
   pe_out_collector_if.slave bus
);
   localparam int RW = (X > 1) ? $clog2(X) : 1;
   localparam int CW = (Y > 1) ? $clog2(Y) : 1;
   localparam int AW = $clog2(BUF_DEPTH);
   localparam int PW = AW + 1;

   logic [X-1:0]         dly [RD_LAT];
   logic [X-1:0]         cap_en;
   logic [CW-1:0]        col_cnt [X];
   logic [OUT_LEN-1:0]   mem_data [BUF_DEPTH];
   logic [RW-1:0]        mem_row [BUF_DEPTH];
   logic [CW-1:0]        mem_col [BUF_DEPTH];
   logic [BUF_DEPTH-1:0] mem_last;
   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rd_ptr;
   logic                 empty;
   logic                 full;
   logic                 pop;
   logic                 push;
   logic                 cap_any;
   logic                 multi;
   logic                 dly_any;
   logic [OUT_LEN-1:0]   sel_data;
   logic [RW-1:0]        sel_row;
   logic [CW-1:0]        sel_col;
   logic                 sel_last;
   logic                 overflow_q;
   logic                 collide_q;

   // Strobes arrive RD_LAT cycles ahead of their data, so the oldest delay stage is the capture enable
   assign cap_en = dly[RD_LAT-1];

   // Pick the lowest strobed lane, detect multi-lane collisions, and summarise the delay line
   always_comb begin
      cap_any  = 1'b0;
      multi    = 1'b0;
      sel_data = '0;
      sel_row  = '0;
      sel_col  = '0;
      dly_any  = 1'b0;
      for (int j = X - 1; j >= 0; j--) begin
         if (cap_en[j]) begin
            multi    = multi | cap_any;
            cap_any  = 1'b1;
            sel_data = bus.out_data[j*OUT_LEN +: OUT_LEN];
            sel_row  = RW'(j);
            sel_col  = col_cnt[j];
         end
      end
      sel_last = (sel_row == RW'(X - 1)) && (sel_col == CW'(Y - 1));
      for (int k = 0; k < RD_LAT; k++) begin
         dly_any = dly_any | (|dly[k]);
      end
   end

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop   = !empty && bus.res_rdy;
   // A full buffer still accepts a capture when the head leaves in the same cycle
   assign push  = cap_any && (!full || pop);

   // Delay line, per-lane column counters, buffer pointers and sticky flags; clear beats push/pop
   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         for (int k = 0; k < RD_LAT; k++) dly[k] <= '0;
         for (int j = 0; j < X; j++) col_cnt[j] <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         overflow_q <= 1'b0;
         collide_q  <= 1'b0;
      end else if (bus.clear) begin
         for (int k = 0; k < RD_LAT; k++) dly[k] <= '0;
         for (int j = 0; j < X; j++) col_cnt[j] <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         overflow_q <= 1'b0;
         collide_q  <= 1'b0;
      end else begin
         dly[0] <= bus.out_rd_en;
         for (int k = 1; k < RD_LAT; k++) dly[k] <= dly[k-1];
         // Every strobed lane advances its column, even the ones lost to a collision
         for (int j = 0; j < X; j++) begin
            if (cap_en[j]) begin
               col_cnt[j] <= (col_cnt[j] == CW'(Y - 1)) ? '0 : col_cnt[j] + CW'(1);
            end
         end
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (cap_any && !push) overflow_q <= 1'b1;
         if (multi) collide_q <= 1'b1;
      end
   end

   // Buffer storage; slots are only visible once the write pointer has passed them
   always_ff @(posedge clk) begin
      if (push && !bus.clear) begin
         mem_data[wr_ptr[AW-1:0]] <= sel_data;
         mem_row[wr_ptr[AW-1:0]]  <= sel_row;
         mem_col[wr_ptr[AW-1:0]]  <= sel_col;
         mem_last[wr_ptr[AW-1:0]] <= sel_last;
      end
   end

   // Head entry straight from storage flops; forced to zero while empty so reset shows all zeros
   assign bus.res_val  = !empty;
   assign bus.res_data = empty ? '0 : mem_data[rd_ptr[AW-1:0]];
   assign bus.res_row  = empty ? '0 : mem_row[rd_ptr[AW-1:0]];
   assign bus.res_col  = empty ? '0 : mem_col[rd_ptr[AW-1:0]];
   assign bus.res_last = empty ? 1'b0 : mem_last[rd_ptr[AW-1:0]];
   assign bus.busy     = dly_any || !empty;
   assign bus.overflow = overflow_q;
   assign bus.collide  = collide_q;
endmodule

// File: tb/tb_pe_out_collector.sv
// Randomised and directed bench for pe_out_collector against a queue-based reference model.
// Latency: model predicts every output cycle by cycle, including the RD_LAT+1 first-result delay.
// Backpressure: res_rdy is varied per cycle; drops and stalls are predicted by the model.
module tb_pe_out_collector;
   localparam int X      = 3;
   localparam int Y      = 3;
   localparam int L      = 8;
   localparam int RD_LAT = 1;
   localparam int DEPTH  = 8;

   logic clk = 1'b0;
   logic sys_rst_n;
   always #5 clk = ~clk;

   pe_out_collector_if #(.X(X), .Y(Y), .OUT_LEN(L)) bus ();

   pe_out_collector #(
      .X(X), .Y(Y), .OUT_LEN(L), .RD_LAT(RD_LAT), .BUF_DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .sys_rst_n(sys_rst_n),
      .bus(bus)
   );

   typedef struct {
      logic [L-1:0] data;
      int           row;
      int           col;
      logic         last;
   } ent_t;

   ent_t         q[$];
   logic [X-1:0] sq[$];
   int           col[X];
   logic         ov;
   logic         co;
   int           errors = 0;
   int           checks = 0;
   int           cyc_no = 0;
   int           val_seen_at = -1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc_no);
      end
   endtask

   function automatic void model_reset();
      q.delete();
      sq.delete();
      for (int k = 0; k < RD_LAT; k++) sq.push_back('0);
      for (int j = 0; j < X; j++) col[j] = 0;
      ov = 1'b0;
      co = 1'b0;
   endfunction

   function automatic void model_step(input logic [X-1:0] s, input logic [X*L-1:0] d,
                                      input logic r, input logic c);
      logic [X-1:0] cap;
      int           js;
      ent_t         e;
      if (c) begin
         model_reset();
         return;
      end
      cap = sq.pop_front();
      sq.push_back(s);
      if (q.size() > 0 && r) q.delete(0);
      if (cap != '0) begin
         js = -1;
         for (int j = 0; j < X; j++) begin
            if (cap[j] && js < 0) js = j;
         end
         e.data = d[js*L +: L];
         e.row  = js;
         e.col  = col[js];
         e.last = (js == X - 1) && (col[js] == Y - 1);
         if ($countones(cap) > 1) co = 1'b1;
         for (int j = 0; j < X; j++) begin
            if (cap[j]) col[j] = (col[j] + 1) % Y;
         end
         if (q.size() < DEPTH) q.push_back(e);
         else ov = 1'b1;
      end
   endfunction

   task automatic compare();
      logic eb;
      eb = (q.size() > 0);
      foreach (sq[k]) if (sq[k] != '0) eb = 1'b1;
      chk("res_val", bus.res_val, q.size() > 0);
      if (q.size() > 0) begin
         chk("res_data", bus.res_data, q[0].data);
         chk("res_row", bus.res_row, q[0].row);
         chk("res_col", bus.res_col, q[0].col);
         chk("res_last", bus.res_last, q[0].last);
      end
      chk("busy", bus.busy, eb);
      chk("overflow", bus.overflow, ov);
      chk("collide", bus.collide, co);
      if (bus.res_val && val_seen_at < 0) val_seen_at = cyc_no;
   endtask

   // One clock: drive just after posedge, check at negedge, advance model for the coming edge
   task automatic cyc(input logic [X-1:0] s, input logic [X*L-1:0] d, input logic r, input logic c);
      bus.out_rd_en = s;
      bus.out_data  = d;
      bus.res_rdy   = r;
      bus.clear     = c;
      @(negedge clk);
      compare();
      model_step(s, d, r, c);
      @(posedge clk);
      #1;
      cyc_no++;
   endtask

   function automatic logic [X*L-1:0] rnd_data();
      logic [X*L-1:0] d;
      for (int j = 0; j < X; j++) d[j*L +: L] = L'($urandom);
      return d;
   endfunction

   task automatic idle(input int n, input logic r);
      for (int k = 0; k < n; k++) cyc('0, rnd_data(), r, 1'b0);
   endtask

   // Staggered frame: lane i strobed Y consecutive cycles, data 0x{row}{col} 1-based in capture cycle
   task automatic frame(input logic r, input int tail);
      logic [X-1:0]   s;
      logic [X*L-1:0] d;
      int             kk;
      for (int k = 0; k < X * Y + RD_LAT + tail; k++) begin
         s = '0;
         if (k < X * Y) s[k / Y] = 1'b1;
         d = rnd_data();
         kk = k - RD_LAT;
         if (kk >= 0 && kk < X * Y) d[(kk / Y)*L +: L] = L'(((kk / Y + 1) << 4) | (kk % Y + 1));
         cyc(s, d, r, 1'b0);
      end
   endtask

   task automatic async_reset();
      #2;
      sys_rst_n = 1'b0;
      #1;
      chk("arst_res_val", bus.res_val, 0);
      chk("arst_res_data", bus.res_data, 0);
      chk("arst_res_row", bus.res_row, 0);
      chk("arst_res_col", bus.res_col, 0);
      chk("arst_res_last", bus.res_last, 0);
      chk("arst_busy", bus.busy, 0);
      chk("arst_overflow", bus.overflow, 0);
      chk("arst_collide", bus.collide, 0);
      model_reset();
      bus.out_rd_en = '0;
      bus.res_rdy   = 1'b0;
      bus.clear     = 1'b0;
      @(negedge clk);
      sys_rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc_no++;
   endtask

   logic [X*L-1:0] dd;
   int             start;

   initial begin
      sys_rst_n     = 1'b0;
      bus.out_rd_en = '0;
      bus.out_data  = '0;
      bus.res_rdy   = 1'b0;
      bus.clear     = 1'b0;
      model_reset();
      #1;
      chk("rst_res_val", bus.res_val, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_res_data", bus.res_data, 0);
      @(negedge clk);
      @(negedge clk);
      sys_rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Full frame with the consumer always ready
      idle(9, 1'b1);
      start = cyc_no;
      val_seen_at = -1;
      frame(1'b1, 6);
      chk("first_val_latency", val_seen_at - start, RD_LAT + 1);

      // Backpressure across the whole frame, then drain
      frame(1'b0, 2);
      idle(12, 1'b1);

      // Fill the buffer, then capture while popping
      cyc('0, '0, 1'b0, 1'b1);
      for (int k = 0; k < DEPTH; k++) cyc(3'b001, rnd_data(), 1'b0, 1'b0);
      cyc(3'b001, rnd_data(), 1'b0, 1'b0);
      cyc('0, rnd_data(), 1'b1, 1'b0);
      idle(3, 1'b0);
      idle(DEPTH + 3, 1'b1);

      // Collision: lanes 1 and 2 together, then lane 2 alone shows its advanced column
      cyc('0, '0, 1'b0, 1'b1);
      cyc(3'b011, rnd_data(), 1'b0, 1'b0);
      dd = rnd_data();
      dd[0 +: L] = 8'hA1;
      dd[L +: L] = 8'hB2;
      cyc(3'b010, dd, 1'b0, 1'b0);
      dd[L +: L] = 8'hC2;
      cyc('0, dd, 1'b0, 1'b0);
      idle(4, 1'b1);

      // Clear mid-frame, then the next lane-1 strobe restarts at column 0
      for (int k = 0; k < 4; k++) cyc(3'b001, rnd_data(), 1'b0, 1'b0);
      idle(RD_LAT, 1'b0);
      cyc('0, rnd_data(), 1'b0, 1'b1);
      cyc(3'b001, rnd_data(), 1'b0, 1'b0);
      idle(4, 1'b1);

      // Asynchronous reset with traffic pending
      for (int k = 0; k < 4; k++) cyc(3'b100, rnd_data(), 1'b0, 1'b0);
      cyc(3'b110, rnd_data(), 1'b0, 1'b0);
      cyc(3'b001, rnd_data(), 1'b0, 1'b0);
      async_reset();
      cyc(3'b001, rnd_data(), 1'b0, 1'b0);
      idle(4, 1'b1);

      // Randomised traffic with occasional clear and one more asynchronous reset
      for (int k = 0; k < 400; k++) begin
         logic [X-1:0] s;
         int           pick;
         pick = $urandom_range(0, 9);
         if (pick < 6)      s = '0;
         else if (pick < 9) s = X'(1) << $urandom_range(0, X - 1);
         else               s = X'($urandom);
         if (k == 200) async_reset();
         cyc(s, rnd_data(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 63) == 0));
      end
      idle(DEPTH + RD_LAT + 4, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
